// File: rtl/aux_input_conditioner_pkg.sv
// Shared constants for the auxiliary input conditioner.
// Holds the per-channel debounce state encoding, the index of the resume
// button within the conditioned vector, and a helper that turns a target
// rate in Hz into a board-clock cycle count.
package aux_input_conditioner_pkg;

  localparam int BoardClkHz = 100_000_000;

  localparam int ResumeCh = 16;

  typedef enum logic [1:0] {
    ST_LO    = 2'd0,
    ST_LO2HI = 2'd1,
    ST_HI    = 2'd2,
    ST_HI2LO = 2'd3
  } deb_state_e;

  // Number of board-clock cycles in one period of the given rate.
  function automatic int cnt_hz(input int hz);
    return BoardClkHz / hz;
  endfunction

endpackage

// File: rtl/aux_input_conditioner_channel.sv
// One debounced auxiliary input bit.
// Synchronises the raw pin level, qualifies a new level once it has been
// seen on StableCnt consecutive synchronised samples, and produces the
// registered level, one-cycle rise/fall pulses and a sticky rise flag.
//
// Ports:
//   clk    board clock
//   rst_n  synchronous active-low reset
//   raw    asynchronous pin level
//   clr    clears the sticky event flag
//   level  debounced level
//   rise   one-cycle pulse on accepted 0->1
//   fall   one-cycle pulse on accepted 1->0
//   evt    sticky rise flag
//
// state    | meaning
// ---------+------------------------------------------------
// ST_LO    | accepted level 0, input agrees
// ST_LO2HI | accepted level 0, counting consecutive 1 samples
// ST_HI    | accepted level 1, input agrees
// ST_HI2LO | accepted level 1, counting consecutive 0 samples
module aux_input_conditioner_channel
  import aux_input_conditioner_pkg::*;
#(
  parameter int StableCnt = 4,
  parameter int CntBit    = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  input  logic clr,
  output logic level,
  output logic rise,
  output logic fall,
  output logic evt
);

  localparam logic [CntBit-1:0] CntLast = CntBit'(StableCnt - 1);
  localparam logic [CntBit-1:0] CntOne  = CntBit'(1);

  logic [1:0]        sync_q;
  logic              s;
  deb_state_e        state_q, state_d;
  logic [CntBit-1:0] cnt_q, cnt_d;
  logic              level_q, level_d;
  logic              rise_q, rise_d;
  logic              fall_q, fall_d;
  logic              evt_q;

  assign s = sync_q[1];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q  <= 2'b00;
      state_q <= ST_LO;
      cnt_q   <= '0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
      evt_q   <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], raw};
      state_q <= state_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      // Uses the registered rise so a clear landing in the pulse cycle
      // cannot swallow the event.
      evt_q   <= rise_q | (evt_q & ~clr);
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    level_d = level_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    unique case (state_q)
      ST_LO: begin
        if (s) begin
          // A one-sample qualification skips the counting state entirely.
          if (CntLast == '0) begin
            state_d = ST_HI;
            level_d = 1'b1;
            rise_d  = 1'b1;
          end else begin
            state_d = ST_LO2HI;
            cnt_d   = CntOne;
          end
        end
      end
      ST_LO2HI: begin
        if (!s) begin
          state_d = ST_LO;
        end else if (cnt_q == CntLast) begin
          state_d = ST_HI;
          level_d = 1'b1;
          rise_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CntOne;
        end
      end
      ST_HI: begin
        if (!s) begin
          if (CntLast == '0) begin
            state_d = ST_LO;
            level_d = 1'b0;
            fall_d  = 1'b1;
          end else begin
            state_d = ST_HI2LO;
            cnt_d   = CntOne;
          end
        end
      end
      ST_HI2LO: begin
        if (s) begin
          state_d = ST_HI;
        end else if (cnt_q == CntLast) begin
          state_d = ST_LO;
          level_d = 1'b0;
          fall_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CntOne;
        end
      end
      default: begin
        state_d = ST_LO;
        level_d = 1'b0;
      end
    endcase
  end

  assign level = level_q;
  assign rise  = rise_q;
  assign fall  = fall_q;
  assign evt   = evt_q;

endmodule

// File: rtl/aux_input_conditioner.sv
// Debounce and edge-detect for the board's auxiliary inputs.
// Bit 16 is the resume button, bits 15:0 are the slide switches. Every bit
// is handled by an independent channel; all outputs are registered.
//
// Ports:
//   clk    board clock, the only clock in the block
//   rst_n  synchronous active-low reset
//   raw    asynchronous pin levels
//   clr    per-channel clear for the sticky event flag
//   level  debounced levels
//   rise   one-cycle pulses on accepted 0->1 changes
//   fall   one-cycle pulses on accepted 1->0 changes
//   evt    sticky rise flags for slow-clock consumers
module aux_input_conditioner
  import aux_input_conditioner_pkg::*;
#(
  parameter int NCh       = 17,
  parameter int StableCnt = cnt_hz(100),
  parameter int CntBit    = 20
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [NCh-1:0] raw,
  input  logic [NCh-1:0] clr,
  output logic [NCh-1:0] level,
  output logic [NCh-1:0] rise,
  output logic [NCh-1:0] fall,
  output logic [NCh-1:0] evt
);

  for (genvar i = 0; i < NCh; i++) begin : g_ch
    aux_input_conditioner_channel #(
      .StableCnt(StableCnt),
      .CntBit   (CntBit)
    ) u_ch (
      .clk  (clk),
      .rst_n(rst_n),
      .raw  (raw[i]),
      .clr  (clr[i]),
      .level(level[i]),
      .rise (rise[i]),
      .fall (fall[i]),
      .evt  (evt[i])
    );
  end

endmodule

// File: tb/tb_aux_input_conditioner.sv
// Directed bench for aux_input_conditioner with StableCnt=4, CntBit=3.
// Inputs change 1 time unit after a rising edge; outputs are checked at
// the same point, i.e. right after the edge that produced them.
module tb_aux_input_conditioner;

  localparam int NCh = 17;
  localparam logic [NCh-1:0] Zero = '0;
  localparam logic [NCh-1:0] Ones = '1;
  localparam logic [NCh-1:0] B0   = 17'h00001;
  localparam logic [NCh-1:0] B3   = 17'h00008;
  localparam logic [NCh-1:0] B5   = 17'h00020;
  localparam logic [NCh-1:0] B16  = 17'h10000;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [NCh-1:0] raw;
  logic [NCh-1:0] clr;
  logic [NCh-1:0] level;
  logic [NCh-1:0] rise;
  logic [NCh-1:0] fall;
  logic [NCh-1:0] evt;

  int n_tests = 0;
  int n_fail  = 0;

  aux_input_conditioner #(
    .NCh      (NCh),
    .StableCnt(4),
    .CntBit   (3)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .raw  (raw),
    .clr  (clr),
    .level(level),
    .rise (rise),
    .fall (fall),
    .evt  (evt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [NCh-1:0] obs,
                     input logic [NCh-1:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %05h expected %05h", tag, obs, exp);
    end
  endtask

  logic [NCh-1:0] acc;

  initial begin
    rst_n = 1'b0;
    raw   = Ones;
    clr   = Zero;

    // reset with all inputs high
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("rst_level", level, Zero);
      chk("rst_pulse_evt", rise | fall | evt, Zero);
    end
    rst_n = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      tick();
      chk("post_rst_wait", level | rise, Zero);
    end
    tick();
    chk("post_rst_level", level, Ones);
    chk("post_rst_rise", rise, Ones);
    tick();
    chk("post_rst_rise_end", rise, Zero);
    chk("post_rst_evt", evt, Ones);
    clr = Ones;
    tick();
    chk("clr_all_evt", evt, Zero);
    chk("clr_keeps_level", level, Ones);
    clr = Zero;

    // all channels fall together
    raw = Zero;
    for (int k = 1; k <= 5; k++) tick();
    chk("all_fall_wait", level, Ones);
    tick();
    chk("all_fall_pulse", fall, Ones);
    chk("all_fall_level", level, Zero);
    tick();
    chk("all_fall_end", fall, Zero);

    // single channel 0 rise and fall
    raw = B0;
    for (int k = 1; k <= 5; k++) tick();
    chk("ch0_rise_wait", level | rise, Zero);
    tick();
    chk("ch0_level", level, B0);
    chk("ch0_rise", rise, B0);
    tick();
    chk("ch0_rise_end", rise, Zero);
    chk("ch0_evt", evt, B0);
    raw = Zero;
    for (int k = 1; k <= 5; k++) tick();
    chk("ch0_fall_wait", level, B0);
    tick();
    chk("ch0_fall", fall, B0);
    chk("ch0_level_low", level, Zero);
    clr = B0;
    tick();
    clr = Zero;
    chk("ch0_fall_end", fall, Zero);
    chk("ch0_evt_clr", evt, Zero);

    // bouncing resume button, then settled high
    acc = Zero;
    for (int i = 0; i < 8; i++) begin
      raw[16] = ((i / 2) % 2) == 0;
      tick();
      acc |= rise | fall | level;
    end
    raw[16] = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      tick();
      acc |= rise | fall | level;
    end
    chk("bounce_quiet", acc, Zero);
    tick();
    chk("bounce_settle_level", level, B16);
    chk("bounce_settle_rise", rise, B16);
    tick();
    chk("bounce_rise_end", rise, Zero);
    clr = B16;
    tick();
    clr = Zero;
    chk("ch16_evt_clr", evt, Zero);

    // short pulse on channel 5 is rejected
    acc = Zero;
    raw[5] = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      acc |= rise | fall | evt;
    end
    raw[5] = 1'b0;
    for (int k = 0; k < 10; k++) begin
      tick();
      acc |= rise | fall | evt | (level & B5);
    end
    chk("short_pulse_quiet", acc, Zero);
    chk("short_pulse_level", level, B16);

    // rise coincident with clear keeps the event
    raw[16] = 1'b0;
    for (int k = 1; k <= 5; k++) tick();
    tick();
    chk("ch16_fall", fall, B16);
    tick();
    raw[16] = 1'b1;
    for (int k = 1; k <= 5; k++) tick();
    tick();
    chk("ch16_rise", rise, B16);
    chk("ch16_evt_before", evt, Zero);
    clr = B16;
    tick();
    chk("ch16_evt_coincident", evt, B16);
    chk("ch16_rise_end", rise, Zero);
    tick();
    chk("ch16_evt_cleared", evt, Zero);
    clr = Zero;

    // reset in the middle of qualifying channel 3
    raw[3] = 1'b1;
    for (int k = 0; k < 4; k++) tick();
    chk("mid_qual_level", level, B16);
    rst_n = 1'b0;
    tick();
    chk("mid_rst_level", level, Zero);
    chk("mid_rst_pulse", rise | fall, Zero);
    rst_n = 1'b1;
    tick();
    chk("mid_rst_after_pulse", rise | fall, Zero);
    for (int k = 2; k <= 5; k++) begin
      tick();
      chk("mid_rst_wait", level | rise, Zero);
    end
    tick();
    chk("mid_rst_level_up", level, B16 | B3);
    chk("mid_rst_rise", rise, B16 | B3);
    tick();
    chk("mid_rst_rise_end", rise, Zero);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/aux_input_conditioner.md
AUX_INPUT_CONDITIONER -- requirements
Module: aux_input_conditioner

Interface
REQ-001 SHALL have parameter NCh, default 17, number of conditioned channels (bit 16 = resume button, bits 15:0 = swt).
REQ-002 SHALL have parameter StableCnt, default `CNT_HZ(100)`, the number of consecutive equal synchronised samples needed to accept a new level (10 ms at board clock); legal range 1..2^CntBit-1.
REQ-003 SHALL have parameter CntBit, default 20, stability-counter width.
REQ-004 SHALL have port clk  input  1  board clock; the only clock in the block.
REQ-005 SHALL have port rst_n  input  1  reset; synchronous, active-low.
REQ-006 SHALL have port raw  input  NCh  asynchronous pin levels (button, switches).
REQ-007 SHALL have port clr  input  NCh  per-channel clear for the sticky event flag.
REQ-008 SHALL have port level  output  NCh  debounced level.
REQ-009 SHALL have port rise  output  NCh  one-cycle pulse on the accepted 0->1 change.
REQ-010 SHALL have port fall  output  NCh  one-cycle pulse on the accepted 1->0 change.
REQ-011 SHALL have port evt  output  NCh  sticky rise flag, held for slow-clock consumers (core-clock halt/resume logic).

Function
REQ-012 Each raw bit SHALL pass through a 2-flop synchroniser; only the second flop output (s) feeds the FSM.
REQ-013 Per channel, the FSM SHALL have states LO, LO2HI, HI, HI2LO.
REQ-014 LO: s=1 -> LO2HI, cnt<=1; otherwise stay, cnt<=0.
REQ-015 LO2HI: s=0 -> LO, cnt<=0 (bounce discarded); s=1 and cnt==StableCnt-1 -> HI; else cnt<=cnt+1.
REQ-016 HI and HI2LO SHALL mirror REQ-014/015 with polarity inverted.
REQ-017 The LO2HI->HI transition edge SHALL set level=1 and assert rise for exactly that one cycle; the HI2LO->LO transition edge SHALL clear level and assert fall for one cycle.
REQ-018 With StableCnt=1, LO SHALL go directly to HI on the first s=1 sample (LO2HI not visited); HI to LO likewise.
REQ-019 Latency: a clean raw change held steady SHALL appear on level/rise exactly StableCnt+2 clock edges after the first edge that samples it.
REQ-020 A raw pulse shorter than StableCnt cycles (after synchronisation) SHALL produce no change on level, rise, fall or evt.
REQ-021 cnt SHALL never exceed StableCnt-1; no wrap-around is possible.
REQ-022 evt[i] SHALL be set on rise[i] and cleared on clr[i]; if both occur in the same cycle, evt[i] SHALL be 1 (no event lost).
REQ-023 clr SHALL have no effect on level, rise, fall or FSM state.
REQ-024 Channels SHALL be fully independent; simultaneous events on any set of channels SHALL each be handled per REQ-014..022.

Reset
REQ-025 While rst_n=0 at a clk edge: synchronisers=0, FSM=LO, cnt=0, level=0, rise=0, fall=0, evt=0.
REQ-026 Reset mid-qualification SHALL discard the partial count; no rise/fall pulse SHALL be emitted on that edge or the edge after.
REQ-027 A raw bit held high through reset SHALL yield level=1 and one rise pulse StableCnt+2 edges after the first edge with rst_n=1.

Structure
REQ-028 State encoding constants (2-bit LO/LO2HI/HI/HI2LO) and the resume channel index SHALL live in the shared Auxiliary.vh header next to CNT_HZ.
REQ-029 One sub-module, AuxDebounceChannel (synchroniser + FSM + counter + evt for one bit), SHALL be instantiated NCh times via generate.
REQ-030 All outputs SHALL be registered; no combinational path from raw or clr to any output.

Verification (StableCnt=4, CntBit=3)
REQ-031 raw=all-ones, rst_n=0 for 3 edges -> all outputs 0 during reset; level=all-ones and rise=all-ones for one cycle at edge 6 after release.
REQ-032 raw[0] 0->1 held -> level[0]=1 and single rise[0] pulse 6 edges later; other channels unchanged; release -> fall[0] 6 edges later.
REQ-033 raw[16] toggles 1,0,1,0 every 2 cycles then holds 1 -> no pulses during bounce; level[16] rises exactly 6 edges after final settle.
REQ-034 raw[5] high for 3 cycles then low -> level, rise, fall, evt stay 0.
REQ-035 rise[16] coincident with clr[16]=1 -> evt[16]=1; clr[16]=1 next cycle -> evt[16]=0.
REQ-036 rst_n=0 for 1 edge while raw[3] is 2 cycles into qualification -> no pulse; level[3] rises 6 edges after reset release.
